// File: rtl/gcm_msg_sequencer.sv
// gcm_msg_sequencer: sequences one AES-GCM message through the core (hash key, AAD, payload, length/tag)
module gcm_msg_sequencer #(
  parameter int CNT_W  = 16,
  parameter int TO_CYC = 4096
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iStart,
  input  logic             iEncdec,
  input  logic             iKeylen,
  input  logic [255:0]     iKey,
  input  logic [95:0]      iIV,
  input  logic [127:0]     iTag,
  input  logic [CNT_W-1:0] iAad_blks,
  input  logic [CNT_W-1:0] iPt_blks,
  input  logic [127:0]     iData,
  input  logic             iData_valid,
  output logic             oData_ready,
  output logic             oCore_init,
  output logic             oCore_encdec,
  output logic             oCore_keylen,
  output logic [255:0]     oCore_key,
  output logic             oCore_key_valid,
  output logic [95:0]      oCore_iv,
  output logic             oCore_iv_valid,
  output logic [127:0]     oCore_aad,
  output logic             oCore_aad_valid,
  output logic             oCore_aad_last,
  output logic [127:0]     oCore_block,
  output logic             oCore_block_valid,
  output logic             oCore_block_last,
  output logic [127:0]     oCore_tag,
  output logic             oCore_tag_valid,
  input  logic             iCore_ready,
  input  logic             iCore_result_valid,
  input  logic             iCore_tag_valid,
  input  logic             iCore_authentic,
  output logic             oBusy,
  output logic             oDone,
  output logic             oAuth,
  output logic             oError
);
  localparam int WD_W = $clog2(TO_CYC) + 1;
  typedef enum logic [2:0] {IDLE, HKEY, AAD, PT_SEND, PT_WAIT, TAGW, ABORT} state_t;
  state_t state, nxt;
  logic [WD_W-1:0] wd;
  logic seen_low, hs, to, rdy, aad_v, aad_l, blk_v, blk_l;
  logic encdec_r, keylen_r, done_r, auth_r;
  logic [255:0] key_r;
  logic [95:0] iv_r;
  logic [127:0] tag_r;
  logic [CNT_W-1:0] aad_n, pt_n, aad_cnt, pt_cnt;
  logic [63:0] len_a, len_c;
  assign to = wd == WD_W'(TO_CYC - 1);
  assign len_a = {{(57 - CNT_W){1'b0}}, aad_n, 7'b0};
  assign len_c = {{(57 - CNT_W){1'b0}}, pt_n, 7'b0};
  always_comb begin
    nxt = state;
    rdy = 1'b0;
    hs = 1'b0;
    aad_v = 1'b0;
    aad_l = 1'b0;
    blk_v = 1'b0;
    blk_l = 1'b0;
    case (state)
      IDLE: nxt = iStart ? HKEY : IDLE;
      HKEY: nxt = (iCore_ready && seen_low) ? AAD : to ? ABORT : HKEY;
      AAD: begin
        rdy = aad_n != '0;
        hs = rdy && iData_valid;
        aad_v = hs;
        aad_l = !rdy || (hs && aad_cnt == aad_n - CNT_W'(1));
        nxt = aad_l ? PT_SEND : AAD;
      end
      PT_SEND: begin
        rdy = pt_n != '0;
        hs = rdy && iData_valid;
        blk_v = hs;
        blk_l = !rdy || (hs && pt_cnt == pt_n - CNT_W'(1));
        nxt = !rdy ? TAGW : hs ? PT_WAIT : PT_SEND;
      end
      PT_WAIT: nxt = iCore_result_valid ? (pt_cnt == pt_n ? TAGW : PT_SEND) : to ? ABORT : PT_WAIT;
      TAGW: nxt = iCore_tag_valid ? IDLE : to ? ABORT : TAGW;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state <= IDLE;
      wd <= '0;
      seen_low <= 1'b0;
      done_r <= 1'b0;
      auth_r <= 1'b0;
      encdec_r <= 1'b0;
      keylen_r <= 1'b0;
      key_r <= '0;
      iv_r <= '0;
      tag_r <= '0;
      aad_n <= '0;
      pt_n <= '0;
      aad_cnt <= '0;
      pt_cnt <= '0;
    end else begin
      state <= nxt;
      wd <= (nxt != state || hs) ? '0 : wd + WD_W'(1);
      seen_low <= state == HKEY && (seen_low || !iCore_ready);
      done_r <= state == TAGW && iCore_tag_valid;
      if (state == IDLE && iStart) begin
        encdec_r <= iEncdec;
        keylen_r <= iKeylen;
        key_r <= iKey;
        iv_r <= iIV;
        tag_r <= iTag;
        aad_n <= iAad_blks;
        pt_n <= iPt_blks;
        aad_cnt <= '0;
        pt_cnt <= '0;
        auth_r <= 1'b0;
      end
      if (state == TAGW && iCore_tag_valid) auth_r <= encdec_r || iCore_authentic;
      if (state == AAD && hs) aad_cnt <= aad_cnt + CNT_W'(1);
      if (state == PT_SEND && hs) pt_cnt <= pt_cnt + CNT_W'(1);
    end
  end
  assign oData_ready = rdy;
  assign oCore_init = state inside {HKEY, AAD, PT_SEND, PT_WAIT, TAGW};
  assign oCore_encdec = encdec_r;
  assign oCore_keylen = keylen_r;
  assign oCore_key = key_r;
  assign oCore_key_valid = state == HKEY;
  assign oCore_iv = iv_r;
  assign oCore_iv_valid = state == HKEY;
  assign oCore_aad = aad_v ? iData : state == TAGW ? {len_a, len_c} : '0;
  assign oCore_aad_valid = aad_v;
  assign oCore_aad_last = aad_l;
  assign oCore_block = blk_v ? iData : '0;
  assign oCore_block_valid = blk_v;
  assign oCore_block_last = blk_l;
  assign oCore_tag = tag_r;
  assign oCore_tag_valid = state == HKEY && wd == '0;
  assign oBusy = state != IDLE;
  assign oDone = done_r;
  assign oAuth = auth_r;
  assign oError = state == ABORT;
endmodule

// File: tb/tb_gcm_msg_sequencer.sv
// tb_gcm_msg_sequencer: scoreboard bench with a behavioural core and block source
module tb_gcm_msg_sequencer;
  localparam int CW = 16;
  localparam int K_AAD = 1, K_BLK = 2, K_LEN = 3, K_DONE = 4, K_ERR = 5;
  localparam logic [127:0] GOOD = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [255:0] KEY = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [95:0] IV = 96'hcafebabe_facedbad_decaf888;
  typedef struct {
    int k;
    logic [127:0] d;
    logic v;
    logic l;
  } ev_t;
  logic iClk = 1'b0, iRstn = 1'b0;
  logic iStart = 1'b0, iEncdec = 1'b0, iKeylen = 1'b0;
  logic [255:0] iKey = '0;
  logic [95:0] iIV = '0;
  logic [127:0] iTag = '0, iData = '0;
  logic [CW-1:0] iAad_blks = '0, iPt_blks = '0;
  logic iData_valid = 1'b0, oData_ready;
  logic oCore_init, oCore_encdec, oCore_keylen, oCore_key_valid, oCore_iv_valid;
  logic [255:0] oCore_key;
  logic [95:0] oCore_iv;
  logic [127:0] oCore_aad, oCore_block, oCore_tag;
  logic oCore_aad_valid, oCore_aad_last, oCore_block_valid, oCore_block_last, oCore_tag_valid;
  logic iCore_ready = 1'b1, iCore_result_valid = 1'b0, iCore_tag_valid = 1'b0, iCore_authentic = 1'b0;
  logic oBusy, oDone, oAuth, oError;
  ev_t exp_q[$];
  logic [127:0] src_q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, stall = 0, gap_cnt = 0, res_count = 0, blk_cyc = 0, err_cyc = 0;
  logic no_tag = 1'b0;

  gcm_msg_sequencer #(.CNT_W(CW), .TO_CYC(64)) dut (
    .iClk(iClk), .iRstn(iRstn), .iStart(iStart), .iEncdec(iEncdec), .iKeylen(iKeylen),
    .iKey(iKey), .iIV(iIV), .iTag(iTag), .iAad_blks(iAad_blks), .iPt_blks(iPt_blks),
    .iData(iData), .iData_valid(iData_valid), .oData_ready(oData_ready),
    .oCore_init(oCore_init), .oCore_encdec(oCore_encdec), .oCore_keylen(oCore_keylen),
    .oCore_key(oCore_key), .oCore_key_valid(oCore_key_valid), .oCore_iv(oCore_iv),
    .oCore_iv_valid(oCore_iv_valid), .oCore_aad(oCore_aad), .oCore_aad_valid(oCore_aad_valid),
    .oCore_aad_last(oCore_aad_last), .oCore_block(oCore_block), .oCore_block_valid(oCore_block_valid),
    .oCore_block_last(oCore_block_last), .oCore_tag(oCore_tag), .oCore_tag_valid(oCore_tag_valid),
    .iCore_ready(iCore_ready), .iCore_result_valid(iCore_result_valid), .iCore_tag_valid(iCore_tag_valid),
    .iCore_authentic(iCore_authentic), .oBusy(oBusy), .oDone(oDone), .oAuth(oAuth), .oError(oError)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic logic all_out();
    return |{oData_ready, oCore_init, oCore_encdec, oCore_keylen, oCore_key, oCore_key_valid, oCore_iv,
             oCore_iv_valid, oCore_aad, oCore_aad_valid, oCore_aad_last, oCore_block, oCore_block_valid,
             oCore_block_last, oCore_tag, oCore_tag_valid, oBusy, oDone, oAuth, oError};
  endfunction

  task automatic cmp(input string nm, input logic [255:0] got, input logic [255:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check(input string nm, input int k, input logic [127:0] d, input logic v, input logic l);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event d=%h v=%b l=%b with nothing expected", nm, d, v, l);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.d !== d || e.v !== v || e.l !== l) begin
        n_fail++;
        $display("FAIL %s: got kind=%0d d=%h v=%b l=%b, want kind=%0d d=%h v=%b l=%b",
                 nm, k, d, v, l, e.k, e.d, e.v, e.l);
      end
    end
  endtask

  // monitor: every DUT-visible event is matched against the scoreboard
  initial forever begin
    @(negedge iClk);
    if (iRstn) begin
      if (oCore_aad_valid || oCore_aad_last) check("aad", K_AAD, oCore_aad, oCore_aad_valid, oCore_aad_last);
      if (oCore_block_valid || oCore_block_last) begin
        check("block", K_BLK, oCore_block, oCore_block_valid, oCore_block_last);
        if (oCore_block_last) blk_cyc = cyc;
      end
      if (iCore_tag_valid && oCore_init) check("len_block", K_LEN, oCore_aad, 1'b0, 1'b0);
      if (oDone) check("done_auth", K_DONE, '0, 1'b0, oAuth);
      if (oError) begin
        check("abort", K_ERR, '0, oCore_init, 1'b0);
        err_cyc = cyc;
      end
    end
  end

  // block source with optional gap after each accepted block
  initial begin
    logic hs;
    forever begin
      @(negedge iClk);
      hs = iData_valid && oData_ready;
      @(posedge iClk);
      #1;
      if (hs && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap_cnt = stall;
      end else if (gap_cnt > 0) gap_cnt--;
      iData_valid = src_q.size() > 0 && gap_cnt == 0;
      iData = src_q.size() > 0 ? src_q[0] : '0;
    end
  end

  // behavioural core: ready dip after key load, result 4 cycles after a block, tag a few cycles later
  initial begin
    int rdy_cnt, res_cnt, tag_cnt;
    logic last_blk, o_tv, o_bv, o_bl, rstl;
    logic [127:0] t, cap;
    rdy_cnt = 0; res_cnt = 0; tag_cnt = 0; last_blk = 1'b0; cap = '0;
    forever begin
      @(negedge iClk);
      o_tv = oCore_tag_valid; o_bv = oCore_block_valid; o_bl = oCore_block_last; rstl = iRstn; t = oCore_tag;
      @(posedge iClk);
      #1;
      iCore_result_valid = 1'b0;
      iCore_tag_valid = 1'b0;
      if (!rstl) begin
        rdy_cnt = 0; res_cnt = 0; tag_cnt = 0; last_blk = 1'b0;
        iCore_ready = 1'b1;
      end else begin
        if (o_tv) begin
          rdy_cnt = 3;
          cap = t;
        end
        iCore_ready = rdy_cnt == 0;
        if (rdy_cnt > 0) rdy_cnt--;
        if (res_cnt > 0) begin
          res_cnt--;
          if (res_cnt == 0) begin
            iCore_result_valid = 1'b1;
            res_count++;
            if (last_blk) tag_cnt = 4;
          end
        end
        if (o_bv) begin
          res_cnt = 3;
          last_blk = o_bl;
        end
        if (o_bl && !o_bv) tag_cnt = 4;
        if (tag_cnt > 0) begin
          tag_cnt--;
          if (tag_cnt == 0 && !no_tag) begin
            iCore_tag_valid = 1'b1;
            iCore_authentic = cap == GOOD;
          end
        end
      end
    end
  end

  task automatic push_msg(input int na, input int np, input logic auth, input logic [127:0] len, input logic abort);
    logic [127:0] d;
    for (int i = 0; i < na; i++) begin
      d = {32'haad00000 + 32'(i), 96'h01234567_89abcdef_00112233};
      src_q.push_back(d);
      exp_q.push_back('{K_AAD, d, 1'b1, i == na - 1});
    end
    if (na == 0) exp_q.push_back('{K_AAD, '0, 1'b0, 1'b1});
    for (int i = 0; i < np; i++) begin
      d = {32'hda7a0000 + 32'(i), 96'hfedcba98_76543210_44556677};
      src_q.push_back(d);
      exp_q.push_back('{K_BLK, d, 1'b1, i == np - 1});
    end
    if (np == 0) exp_q.push_back('{K_BLK, '0, 1'b0, 1'b1});
    if (abort) exp_q.push_back('{K_ERR, '0, 1'b0, 1'b0});
    else begin
      exp_q.push_back('{K_LEN, len, 1'b0, 1'b0});
      exp_q.push_back('{K_DONE, '0, 1'b0, auth});
    end
  endtask

  task automatic start_msg(input logic enc, input logic kl, input int na, input int np, input logic [127:0] tag);
    @(posedge iClk);
    #1;
    iStart = 1'b1; iEncdec = enc; iKeylen = kl; iKey = KEY; iIV = IV; iTag = tag;
    iAad_blks = CW'(na); iPt_blks = CW'(np);
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    cmp("hkey_ctrl", 256'({oCore_init, oCore_key_valid, oCore_iv_valid, oCore_tag_valid, oCore_encdec, oCore_keylen}),
        256'({4'b1111, enc, kl}));
    cmp("hkey_key", oCore_key, KEY);
    cmp("hkey_iv_tag", 256'({oCore_iv, oCore_tag}), 256'({IV, tag}));
  endtask

  task automatic wait_q(input string nm);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
      @(posedge iClk);
      #1;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d events still pending after 2000 cycles, want 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1;
    cmp("reset_outputs", 256'(all_out()), '0);
    repeat (3) @(posedge iClk);
    #1;
    iRstn = 1'b1;
    push_msg(1, 2, 1'b1, {64'h80, 64'h100}, 1'b0);
    start_msg(1'b1, 1'b1, 1, 2, GOOD);
    wait_q("enc_1aad_2pt");
    push_msg(0, 1, 1'b1, {64'h0, 64'h80}, 1'b0);
    start_msg(1'b0, 1'b0, 0, 1, GOOD);
    wait_q("dec_good_tag");
    push_msg(0, 1, 1'b0, {64'h0, 64'h80}, 1'b0);
    start_msg(1'b0, 1'b0, 0, 1, GOOD ^ 128'h1);
    wait_q("dec_bad_tag");
    repeat (3) @(posedge iClk);
    #1;
    cmp("auth_hold", 256'(oAuth), 256'(0));
    push_msg(0, 0, 1'b1, '0, 1'b0);
    start_msg(1'b1, 1'b0, 0, 0, GOOD);
    wait_q("empty_msg");
    stall = 5;
    res_count = 0;
    push_msg(0, 3, 1'b1, {64'h0, 64'h180}, 1'b0);
    start_msg(1'b1, 1'b0, 0, 3, GOOD);
    wait_q("stalled_source");
    cmp("result_count", 256'(res_count), 256'(3));
    stall = 0;
    no_tag = 1'b1;
    push_msg(0, 0, 1'b0, '0, 1'b1);
    start_msg(1'b1, 1'b0, 0, 0, GOOD);
    wait_q("tag_timeout");
    cmp("abort_idle", 256'({oCore_init, oBusy, oError}), '0);
    cmp("abort_delay", 256'(err_cyc - blk_cyc), 256'(65));
    no_tag = 1'b0;
    src_q.push_back({32'hda7a0000, 96'hfedcba98_76543210_44556677});
    src_q.push_back({32'hda7a0001, 96'hfedcba98_76543210_44556677});
    exp_q.push_back('{K_AAD, '0, 1'b0, 1'b1});
    exp_q.push_back('{K_BLK, {32'hda7a0000, 96'hfedcba98_76543210_44556677}, 1'b1, 1'b0});
    start_msg(1'b1, 1'b0, 0, 2, GOOD);
    wait_q("pre_reset");
    cmp("pre_reset_busy", 256'({oBusy, oData_ready}), 256'(2'b10));
    iRstn = 1'b0;
    #1;
    cmp("reset_mid_outputs", 256'(all_out()), '0);
    src_q.delete();
    repeat (3) @(posedge iClk);
    #1;
    iRstn = 1'b1;
    push_msg(1, 1, 1'b1, {64'h80, 64'h80}, 1'b0);
    start_msg(1'b0, 1'b1, 1, 1, GOOD);
    iStart = 1'b1; iEncdec = 1'b1; iPt_blks = CW'(7); iTag = '0;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
    cmp("busy_start_cfg", 256'({oCore_encdec, oCore_tag}), 256'({1'b0, GOOD}));
    wait_q("after_reset_msg");
    repeat (3) @(posedge iClk);
    #1;
    cmp("busy_start_ignored", 256'({oBusy, oAuth}), 256'(2'b01));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 2000000");
    $fatal(1);
  end
endmodule
